gcd_engine: RTL and testbench
=============================

Name: gcd_engine

Overview:
- Parametrised successor of the current GCD controller: one block holding control and datapath for Euclid's algorithm.
- Computes gcd(a,b) by repeated modulo. The modulo is done by an internal restoring shift-subtract divider, so no external ALU or modulo unit is needed.
- Adds a start/busy/done handshake, an abort input, zero-operand error detection and an iteration count output.
- Sits in the same top level as the current controller and replaces its controller, ALU and modulo-unit trio.

Parameters:
- WIDTH, 8, operand and result width in bits (>=2).
- ITER_W, 8, width of the iteration counter (>=1).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset (block in reset while rst=0).
- start_i  input  1  request; sampled only in IDLE.
- abort_i  input  1  cancels a running computation.
- a_i  input  WIDTH  operand A; captured when start is accepted.
- b_i  input  WIDTH  operand B; captured when start is accepted.
- busy_o  output  1  high in every state except IDLE.
- done_o  output  1  one-cycle pulse when the result is valid.
- gcd_o  output  WIDTH  result; held until the next accepted start.
- iter_o  output  ITER_W  number of modulo operations performed; held with gcd_o.
- err_o  output  1  high with done_o when both operands were 0; held with gcd_o.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy_o, done_o, err_o = 0; gcd_o, iter_o and all internal registers = 0.
- States: IDLE, SORT, MOD, CHECK, DONE.
- IDLE:
  - start_i=1 and abort_i=0 at a rising edge: capture a_i and b_i, clear iter and err, go to SORT.
  - start_i while busy is ignored.
  - start_i and abort_i together in IDLE: stay in IDLE.
- SORT (1 cycle):
  - x <= max(A,B), y <= min(A,B).
  - If min=0: gcd <= max, iter=0, err <= (max==0), go to DONE.
  - Otherwise go to MOD.
- MOD (exactly WIDTH cycles):
  - Restoring division of x by y, MSB first.
  - rem is WIDTH+1 bits, cleared on entry. Each cycle: rem = {rem, next bit of x}; if rem >= y then rem = rem - y.
  - Bit counter is $clog2(WIDTH) bits, clamped to a minimum of 1.
  - After WIDTH cycles, r = rem[WIDTH-1:0] = x mod y. Go to CHECK.
- CHECK (1 cycle):
  - iter increments and saturates at 2^ITER_W-1.
  - r==0: gcd <= y, go to DONE.
  - r!=0: x <= y, y <= r, go to MOD.
- DONE (1 cycle): done_o=1; gcd_o, iter_o and err_o update at the DONE entry edge. Go to IDLE.
- Latency: start accepted at edge n, k = number of modulo operations. done_o is high in the cycle following edge n+1+k*(WIDTH+1).
  - Zero operand: k=0, so done_o follows edge n+1.
- abort_i=1 in SORT, MOD, CHECK or DONE: go to IDLE at the next edge.
  - No done_o pulse; gcd_o, iter_o and err_o keep their previous values.
  - abort_i in IDLE has no effect.
- Reset asserted mid-operation: immediate return to the reset values; no done_o pulse.
- Equal operands: x=y, x mod y = 0, so gcd=x and iter=1.
- Operand ordering is irrelevant: gcd(a,b) = gcd(b,a), with identical iter and latency.
- All arithmetic is unsigned. No result exceeds WIDTH bits.

Test Plan:
- WIDTH=8: start with a=12, b=8 at edge n -> done_o pulse after edge n+19; gcd_o=4, iter_o=2, err_o=0. Swapping to a=8, b=12 gives an identical response.
- a=0, b=35 -> done_o after edge n+1, gcd_o=35, iter_o=0, err_o=0. a=0, b=0 -> gcd_o=0, err_o=1.
- Worst case a=233, b=144 -> gcd_o=1, iter_o=11, done_o after edge n+100. a=255, b=254 -> gcd_o=1, iter_o=2. a=7, b=7 -> gcd_o=7, iter_o=1.
- Start 12,8; raise abort_i during the 3rd MOD cycle -> busy_o low after the next edge, no done_o, gcd_o/iter_o keep prior values. A fresh start then completes normally.
- Pulse start_i again while busy -> ignored, result of the first request unchanged. start_i and abort_i together in IDLE -> busy_o stays 0.
- Drive rst=0 asynchronously mid-MOD -> all outputs 0 immediately. Repeat the scenarios with WIDTH=16, ITER_W=3: a=46368, b=28657 -> gcd_o=1, iter_o saturates at 7.

Source files
------------

// File: rtl/gcd_engine_if.sv
// rtl/gcd_engine_if.sv - start/abort request and result bundle for gcd_engine
interface gcd_engine_if #(
    parameter int WIDTH  = 8,
    parameter int ITER_W = 8
);
    logic              start_i;
    logic              abort_i;
    logic [WIDTH-1:0]  a_i;
    logic [WIDTH-1:0]  b_i;
    logic              busy_o;
    logic              done_o;
    logic [WIDTH-1:0]  gcd_o;
    logic [ITER_W-1:0] iter_o;
    logic              err_o;

    modport master (
        output start_i, abort_i, a_i, b_i,
        input  busy_o, done_o, gcd_o, iter_o, err_o
    );

    modport slave (
        input  start_i, abort_i, a_i, b_i,
        output busy_o, done_o, gcd_o, iter_o, err_o
    );
endinterface

// File: rtl/gcd_engine.sv
// rtl/gcd_engine.sv - Euclid GCD engine with built-in restoring shift-subtract modulo
module gcd_engine #(
    parameter int WIDTH  = 8,
    parameter int ITER_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    gcd_engine_if.slave bus
);
    localparam int                CNT_W    = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [ITER_W-1:0] ITER_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SORT,
        S_MOD,
        S_CHECK,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  x_q;
    logic [WIDTH-1:0]  y_q;
    // After each restoring step the remainder is below y, so only the
    // shifted intermediate needs the extra bit; the stored value fits WIDTH.
    logic [WIDTH-1:0]  rem_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ITER_W-1:0] iter_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [WIDTH-1:0]  gcd_q;
    logic [ITER_W-1:0] iter_out_q;

    logic [WIDTH:0]    rem_shift_d;
    logic [WIDTH-1:0]  rem_d;
    logic [WIDTH-1:0]  max_d;
    logic [WIDTH-1:0]  min_d;
    logic [ITER_W-1:0] iter_d;

    // One restoring-division step, operand ordering and saturating iteration count
    always_comb begin
        rem_shift_d = {rem_q, x_q[WIDTH-1]};
        rem_d       = rem_shift_d[WIDTH-1:0];
        if (rem_shift_d >= {1'b0, y_q}) begin
            rem_d = rem_shift_d[WIDTH-1:0] - y_q;
        end
        if (x_q >= y_q) begin
            max_d = x_q;
            min_d = y_q;
        end else begin
            max_d = y_q;
            min_d = x_q;
        end
        iter_d = (iter_q == ITER_MAX) ? iter_q : iter_q + 1'b1;
    end

    // Control FSM and datapath; result registers only change on DONE entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            iter_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            gcd_q      <= '0;
            iter_out_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (state_q != S_IDLE && bus.abort_i) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.start_i && !bus.abort_i) begin
                            x_q     <= bus.a_i;
                            y_q     <= bus.b_i;
                            iter_q  <= '0;
                            busy_q  <= 1'b1;
                            state_q <= S_SORT;
                        end
                    end
                    S_SORT: begin
                        x_q <= max_d;
                        y_q <= min_d;
                        if (min_d == '0) begin
                            gcd_q      <= max_d;
                            iter_out_q <= '0;
                            err_q      <= (max_d == '0);
                            done_q     <= 1'b1;
                            state_q    <= S_DONE;
                        end else begin
                            rem_q   <= '0;
                            cnt_q   <= '0;
                            state_q <= S_MOD;
                        end
                    end
                    S_MOD: begin
                        rem_q <= rem_d;
                        x_q   <= {x_q[WIDTH-2:0], 1'b0};
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            state_q <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        iter_q <= iter_d;
                        if (rem_q == '0) begin
                            gcd_q      <= y_q;
                            iter_out_q <= iter_d;
                            err_q      <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= S_DONE;
                        end else begin
                            x_q     <= y_q;
                            y_q     <= rem_q;
                            rem_q   <= '0;
                            cnt_q   <= '0;
                            state_q <= S_MOD;
                        end
                    end
                    S_DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.busy_o = busy_q;
    assign bus.done_o = done_q;
    assign bus.gcd_o  = gcd_q;
    assign bus.iter_o = iter_out_q;
    assign bus.err_o  = err_q;
endmodule

// File: tb/tb_gcd_engine.sv
// tb/tb_gcd_engine.sv - randomized and directed checks of gcd_engine against a Euclid model
module tb_gcd_engine;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    gcd_engine_if #(.WIDTH(8),  .ITER_W(8)) bus8  ();
    gcd_engine_if #(.WIDTH(16), .ITER_W(3)) bus16 ();

    gcd_engine #(.WIDTH(8),  .ITER_W(8)) u_dut8  (.clk(clk), .rst(rst), .bus(bus8));
    gcd_engine #(.WIDTH(16), .ITER_W(3)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));

    always #5 clk = ~clk;

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Euclid by plain modulo; latency is one SORT cycle plus (width+1) cycles per modulo
    function automatic void ref_gcd(input int a, input int b, input int width, input int iter_max,
                                    output int g, output int it, output int e, output int lat);
        int x, y, t, k;
        x = (a > b) ? a : b;
        y = (a > b) ? b : a;
        k = 0;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
            k++;
        end
        g   = x;
        e   = (a == 0 && b == 0) ? 1 : 0;
        it  = (k > iter_max) ? iter_max : k;
        lat = 1 + k * (width + 1);
    endfunction

    task automatic run8(input int a, input int b, output int g, output int it, output int e,
                        output int lat, output int busy1, output int done_after);
        @(negedge clk);
        bus8.a_i = a[7:0];
        bus8.b_i = b[7:0];
        bus8.start_i = 1'b1;
        @(posedge clk); #1;
        busy1 = int'(bus8.busy_o);
        @(negedge clk);
        bus8.start_i = 1'b0;
        lat = -1;
        for (int c = 1; c <= 1000; c++) begin
            @(posedge clk); #1;
            if (bus8.done_o) begin
                lat = c;
                break;
            end
        end
        g  = int'(bus8.gcd_o);
        it = int'(bus8.iter_o);
        e  = int'(bus8.err_o);
        @(posedge clk); #1;
        done_after = int'(bus8.done_o);
    endtask

    task automatic run16(input int a, input int b, output int g, output int it, output int e,
                         output int lat);
        @(negedge clk);
        bus16.a_i = a[15:0];
        bus16.b_i = b[15:0];
        bus16.start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus16.start_i = 1'b0;
        lat = -1;
        for (int c = 1; c <= 2000; c++) begin
            @(posedge clk); #1;
            if (bus16.done_o) begin
                lat = c;
                break;
            end
        end
        g  = int'(bus16.gcd_o);
        it = int'(bus16.iter_o);
        e  = int'(bus16.err_o);
        @(posedge clk);
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (bus8.busy_o !== 1'b0)   begin n_fail++; $display("FAIL reset_busy8: got %b expected 0", bus8.busy_o); end
        n_checks++; if (bus8.done_o !== 1'b0)   begin n_fail++; $display("FAIL reset_done8: got %b expected 0", bus8.done_o); end
        n_checks++; if (bus8.gcd_o !== 8'd0)    begin n_fail++; $display("FAIL reset_gcd8: got %0d expected 0", bus8.gcd_o); end
        n_checks++; if (bus8.iter_o !== 8'd0)   begin n_fail++; $display("FAIL reset_iter8: got %0d expected 0", bus8.iter_o); end
        n_checks++; if (bus8.err_o !== 1'b0)    begin n_fail++; $display("FAIL reset_err8: got %b expected 0", bus8.err_o); end
        n_checks++; if (bus16.busy_o !== 1'b0)  begin n_fail++; $display("FAIL reset_busy16: got %b expected 0", bus16.busy_o); end
        n_checks++; if (bus16.gcd_o !== 16'd0)  begin n_fail++; $display("FAIL reset_gcd16: got %0d expected 0", bus16.gcd_o); end
        n_checks++; if (bus16.iter_o !== 3'd0)  begin n_fail++; $display("FAIL reset_iter16: got %0d expected 0", bus16.iter_o); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (bus8.busy_o !== 1'b0)   begin n_fail++; $display("FAIL reset_idle_busy8: got %b expected 0", bus8.busy_o); end
    endtask

    task automatic test_directed();
        int ta[8] = '{12, 8, 0, 35, 0, 233, 255, 7};
        int tb[8] = '{8, 12, 35, 0, 0, 144, 254, 7};
        int tg[8] = '{4, 4, 35, 35, 0, 1, 1, 7};
        int ti[8] = '{2, 2, 0, 0, 0, 11, 2, 1};
        int te[8] = '{0, 0, 0, 0, 1, 0, 0, 0};
        int tl[8] = '{19, 19, 1, 1, 1, 100, 19, 10};
        int g, it, e, lat, busy1, done_after;
        for (int i = 0; i < 8; i++) begin
            run8(ta[i], tb[i], g, it, e, lat, busy1, done_after);
            n_checks++; if (g !== tg[i])   begin n_fail++; $display("FAIL directed_gcd(%0d,%0d): got %0d expected %0d", ta[i], tb[i], g, tg[i]); end
            n_checks++; if (it !== ti[i])  begin n_fail++; $display("FAIL directed_iter(%0d,%0d): got %0d expected %0d", ta[i], tb[i], it, ti[i]); end
            n_checks++; if (e !== te[i])   begin n_fail++; $display("FAIL directed_err(%0d,%0d): got %0d expected %0d", ta[i], tb[i], e, te[i]); end
            n_checks++; if (lat !== tl[i]) begin n_fail++; $display("FAIL directed_latency(%0d,%0d): got %0d expected %0d", ta[i], tb[i], lat, tl[i]); end
            n_checks++; if (busy1 !== 1)   begin n_fail++; $display("FAIL directed_busy(%0d,%0d): got %0d expected 1", ta[i], tb[i], busy1); end
            n_checks++; if (done_after !== 0) begin n_fail++; $display("FAIL directed_done_pulse(%0d,%0d): got %0d expected 0", ta[i], tb[i], done_after); end
        end
    endtask

    task automatic test_random8();
        int a, b, m, g, it, e, lat, busy1, done_after, eg, ei, ee, el;
        for (int i = 0; i < 30; i++) begin
            m = $urandom_range(0, 3);
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            if (m == 1) b = $urandom_range(0, 2);
            if (m == 2) b = a;
            if (m == 3) begin
                eg = $urandom_range(1, 15);
                a  = eg * $urandom_range(0, 16);
                b  = eg * $urandom_range(0, 16);
            end
            ref_gcd(a, b, 8, 255, eg, ei, ee, el);
            run8(a, b, g, it, e, lat, busy1, done_after);
            n_checks++; if (g !== eg)   begin n_fail++; $display("FAIL random8_gcd(%0d,%0d): got %0d expected %0d", a, b, g, eg); end
            n_checks++; if (it !== ei)  begin n_fail++; $display("FAIL random8_iter(%0d,%0d): got %0d expected %0d", a, b, it, ei); end
            n_checks++; if (e !== ee)   begin n_fail++; $display("FAIL random8_err(%0d,%0d): got %0d expected %0d", a, b, e, ee); end
            n_checks++; if (lat !== el) begin n_fail++; $display("FAIL random8_latency(%0d,%0d): got %0d expected %0d", a, b, lat, el); end
        end
    endtask

    task automatic test_abort();
        int g, it, e, lat, busy1, done_after, seen;
        run8(7, 7, g, it, e, lat, busy1, done_after);
        n_checks++; if (g !== 7) begin n_fail++; $display("FAIL abort_setup_gcd: got %0d expected 7", g); end
        @(negedge clk);
        bus8.a_i = 8'd12;
        bus8.b_i = 8'd8;
        bus8.start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus8.start_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus8.abort_i = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (bus8.busy_o !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", bus8.busy_o); end
        @(negedge clk);
        bus8.abort_i = 1'b0;
        seen = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk); #1;
            if (bus8.done_o) seen = 1;
        end
        n_checks++; if (seen !== 0)            begin n_fail++; $display("FAIL abort_no_done: got %0d expected 0", seen); end
        n_checks++; if (bus8.gcd_o !== 8'd7)   begin n_fail++; $display("FAIL abort_gcd_held: got %0d expected 7", bus8.gcd_o); end
        n_checks++; if (bus8.iter_o !== 8'd1)  begin n_fail++; $display("FAIL abort_iter_held: got %0d expected 1", bus8.iter_o); end
        n_checks++; if (bus8.err_o !== 1'b0)   begin n_fail++; $display("FAIL abort_err_held: got %b expected 0", bus8.err_o); end
        run8(12, 8, g, it, e, lat, busy1, done_after);
        n_checks++; if (g !== 4)    begin n_fail++; $display("FAIL abort_restart_gcd: got %0d expected 4", g); end
        n_checks++; if (it !== 2)   begin n_fail++; $display("FAIL abort_restart_iter: got %0d expected 2", it); end
        n_checks++; if (lat !== 19) begin n_fail++; $display("FAIL abort_restart_latency: got %0d expected 19", lat); end
    endtask

    task automatic test_start_while_busy();
        int lat;
        @(negedge clk);
        bus8.a_i = 8'd233;
        bus8.b_i = 8'd144;
        bus8.start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus8.start_i = 1'b0;
        lat = -1;
        for (int c = 1; c <= 1000; c++) begin
            @(posedge clk); #1;
            if (bus8.done_o) begin
                lat = c;
                break;
            end
            @(negedge clk);
            bus8.a_i = 8'd10;
            bus8.b_i = 8'd4;
            bus8.start_i = (c == 5 || c == 40 || c == 70);
        end
        bus8.start_i = 1'b0;
        n_checks++; if (lat !== 100)           begin n_fail++; $display("FAIL busy_start_latency: got %0d expected 100", lat); end
        n_checks++; if (bus8.gcd_o !== 8'd1)   begin n_fail++; $display("FAIL busy_start_gcd: got %0d expected 1", bus8.gcd_o); end
        n_checks++; if (bus8.iter_o !== 8'd11) begin n_fail++; $display("FAIL busy_start_iter: got %0d expected 11", bus8.iter_o); end
        @(posedge clk); #1;
        n_checks++; if (bus8.busy_o !== 1'b0)  begin n_fail++; $display("FAIL busy_start_idle: got %b expected 0", bus8.busy_o); end
        @(negedge clk);
        bus8.a_i = 8'd12;
        bus8.b_i = 8'd8;
        bus8.start_i = 1'b1;
        bus8.abort_i = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (bus8.busy_o !== 1'b0)  begin n_fail++; $display("FAIL start_abort_idle_busy: got %b expected 0", bus8.busy_o); end
        @(negedge clk);
        bus8.start_i = 1'b0;
        bus8.abort_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus8.busy_o !== 1'b0)  begin n_fail++; $display("FAIL start_abort_stays_idle: got %b expected 0", bus8.busy_o); end
        n_checks++; if (bus8.gcd_o !== 8'd1)   begin n_fail++; $display("FAIL start_abort_gcd_held: got %0d expected 1", bus8.gcd_o); end
    endtask

    task automatic test_async_reset();
        int g, it, e, lat, busy1, done_after, seen;
        run8(12, 8, g, it, e, lat, busy1, done_after);
        @(negedge clk);
        bus8.a_i = 8'd233;
        bus8.b_i = 8'd144;
        bus8.start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus8.start_i = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        n_checks++; if (bus8.busy_o !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy: got %b expected 0", bus8.busy_o); end
        n_checks++; if (bus8.gcd_o !== 8'd0)  begin n_fail++; $display("FAIL async_reset_gcd: got %0d expected 0", bus8.gcd_o); end
        n_checks++; if (bus8.iter_o !== 8'd0) begin n_fail++; $display("FAIL async_reset_iter: got %0d expected 0", bus8.iter_o); end
        n_checks++; if (bus8.done_o !== 1'b0) begin n_fail++; $display("FAIL async_reset_done: got %b expected 0", bus8.done_o); end
        seen = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (bus8.done_o || bus8.busy_o) seen = 1;
        end
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 110; c++) begin
            @(posedge clk); #1;
            if (bus8.done_o || bus8.busy_o) seen = 1;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL async_reset_quiet: got %0d expected 0", seen); end
        run8(0, 0, g, it, e, lat, busy1, done_after);
        n_checks++; if (e !== 1)    begin n_fail++; $display("FAIL post_reset_err: got %0d expected 1", e); end
        n_checks++; if (lat !== 1)  begin n_fail++; $display("FAIL post_reset_latency: got %0d expected 1", lat); end
        run8(12, 8, g, it, e, lat, busy1, done_after);
        n_checks++; if (g !== 4)    begin n_fail++; $display("FAIL post_reset_gcd: got %0d expected 4", g); end
        n_checks++; if (e !== 0)    begin n_fail++; $display("FAIL post_reset_err_clear: got %0d expected 0", e); end
    endtask

    task automatic test_wide();
        int a, b, g, it, e, lat, eg, ei, ee, el;
        run16(46368, 28657, g, it, e, lat);
        ref_gcd(46368, 28657, 16, 7, eg, ei, ee, el);
        n_checks++; if (g !== 1)    begin n_fail++; $display("FAIL wide_fib_gcd: got %0d expected 1", g); end
        n_checks++; if (it !== 7)   begin n_fail++; $display("FAIL wide_fib_iter: got %0d expected 7", it); end
        n_checks++; if (lat !== el) begin n_fail++; $display("FAIL wide_fib_latency: got %0d expected %0d", lat, el); end
        run16(0, 0, g, it, e, lat);
        n_checks++; if (e !== 1)    begin n_fail++; $display("FAIL wide_zero_err: got %0d expected 1", e); end
        for (int i = 0; i < 15; i++) begin
            a = $urandom_range(0, 65535);
            b = $urandom_range(0, 65535);
            if (i % 4 == 1) begin
                eg = $urandom_range(1, 300);
                a  = eg * $urandom_range(0, 200);
                b  = eg * $urandom_range(0, 200);
            end
            if (i % 4 == 2) b = a;
            ref_gcd(a, b, 16, 7, eg, ei, ee, el);
            run16(a, b, g, it, e, lat);
            n_checks++; if (g !== eg)   begin n_fail++; $display("FAIL wide_gcd(%0d,%0d): got %0d expected %0d", a, b, g, eg); end
            n_checks++; if (it !== ei)  begin n_fail++; $display("FAIL wide_iter(%0d,%0d): got %0d expected %0d", a, b, it, ei); end
            n_checks++; if (e !== ee)   begin n_fail++; $display("FAIL wide_err(%0d,%0d): got %0d expected %0d", a, b, e, ee); end
            n_checks++; if (lat !== el) begin n_fail++; $display("FAIL wide_latency(%0d,%0d): got %0d expected %0d", a, b, lat, el); end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clk = 1'b0;
        rst = 1'b0;
        bus8.start_i  = 1'b0;
        bus8.abort_i  = 1'b0;
        bus8.a_i      = '0;
        bus8.b_i      = '0;
        bus16.start_i = 1'b0;
        bus16.abort_i = 1'b0;
        bus16.a_i     = '0;
        bus16.b_i     = '0;
        test_reset();
        test_directed();
        test_random8();
        test_abort();
        test_start_while_busy();
        test_async_reset();
        test_wide();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
